// File: rtl/battleship_shot_scorer_if.sv
// Shot request / result bundle between the user-input side and the Battleship scorer.
interface battleship_shot_scorer_if #(
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned NUM_SHIPS = 5,
  parameter int unsigned HIT_W     = 5
);
  logic [COORD_W-1:0]   x;
  logic [COORD_W-1:0]   y;
  logic                 big;
  logic                 score;
  logic                 busy;
  logic                 done;
  logic                 hit;
  logic                 near_miss;
  logic                 miss;
  logic [NUM_SHIPS-1:0] biggest_ship;
  logic [NUM_SHIPS-1:0] sunk;
  logic [HIT_W-1:0]     hit_count;
  logic [1:0]           big_left;
  logic                 wrong;
  logic                 game_over;

  modport master (
    output x, y, big, score,
    input  busy, done, hit, near_miss, miss, biggest_ship, sunk, hit_count,
           big_left, wrong, game_over
  );

  modport slave (
    input  x, y, big, score,
    output busy, done, hit, near_miss, miss, biggest_ship, sunk, hit_count,
           big_left, wrong, game_over
  );
endinterface

// File: rtl/battleship_shot_scorer.sv
// Registered Battleship shot scorer: scans one cell per cycle (1 or 3x3), tracks shot cells,
// per-ship damage, sunk ships, big bombs and game over.
module battleship_shot_scorer #(
  parameter int unsigned GRID      = 10,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned ID_W      = 3,
  parameter int unsigned NUM_SHIPS = 5,
  parameter logic [4*NUM_SHIPS-1:0] SHIP_LENS = 20'h54332,
  parameter int unsigned BIG_BOMBS = 2,
  parameter int unsigned HIT_W     = 5
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [GRID*GRID*ID_W-1:0]   ship_map,
  battleship_shot_scorer_if.slave     bus
);

  localparam int unsigned CW     = COORD_W + 1;
  localparam int unsigned CELLS  = GRID * GRID;
  localparam int unsigned LIN_W  = $clog2(CELLS);
  localparam int unsigned MAP_AW = $clog2(CELLS * ID_W);
  localparam int unsigned LEN_AW = $clog2(4 * NUM_SHIPS);
  localparam int unsigned SID_W  = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT, OVER} state_t;

  state_t            state, state_n;
  logic              score_q;
  logic [CW-1:0]     xq, yq;
  logic              bigq;
  logic [1:0]        row_i, col_i;
  logic [CELLS-1:0]  shot;
  logic [3:0]        ship_cnt [NUM_SHIPS];
  logic              acc_hit, acc_near;
  logic [ID_W-1:0]   acc_max;

  logic              start, legal, last_cell;
  logic [CW-1:0]     cur_cx, cur_cy;
  logic [ID_W-1:0]   cur_id, max_n;
  logic [LIN_W-1:0]  cur_lin;
  logic [SID_W-1:0]  sid;
  logic [3:0]        cur_len;
  logic              cur_ship, cur_water, nbr, hit_n, near_n;

  function automatic logic on_board(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    return (cx >= CW'(1)) && (cx <= CW'(GRID)) && (cy >= CW'(1)) && (cy <= CW'(GRID));
  endfunction

  function automatic int unsigned lin_of(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    return (int'(cy) - 1) * GRID + int'(cx) - 1;
  endfunction

  // Off-board coordinates (including the wrapped x-1 at x=0) read as water.
  function automatic logic [ID_W-1:0] id_at(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    if (!on_board(cx, cy)) return '0;
    return ship_map[MAP_AW'(lin_of(cx, cy) * ID_W) +: ID_W];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = legal ? SCAN : REPORT;
      SCAN:    if (last_cell) state_n = REPORT;
      REPORT:  state_n = (&bus.sunk) ? OVER : IDLE;
      OVER:    state_n = OVER;
      default: state_n = IDLE;
    endcase
  end

  // Current scan cell and its contribution to the shot result.
  always_comb begin
    start     = (state == IDLE) && bus.score && !score_q;
    legal     = on_board(CW'(bus.x), CW'(bus.y)) && !(bus.big && (bus.big_left == 2'd0));
    last_cell = !bigq || ((row_i == 2'd2) && (col_i == 2'd2));
    cur_cx    = bigq ? (xq + CW'(col_i) - CW'(1)) : xq;
    cur_cy    = bigq ? (yq + CW'(row_i) - CW'(1)) : yq;
    cur_id    = id_at(cur_cx, cur_cy);
    cur_lin   = LIN_W'(lin_of(cur_cx, cur_cy));
    sid       = SID_W'(cur_id - ID_W'(1));
    cur_len   = SHIP_LENS[LEN_AW'((int'(cur_id) - 1) * 4) +: 4];
    nbr       = (id_at(cur_cx - CW'(1), cur_cy) != '0) || (id_at(cur_cx + CW'(1), cur_cy) != '0) ||
                (id_at(cur_cx, cur_cy - CW'(1)) != '0) || (id_at(cur_cx, cur_cy + CW'(1)) != '0);
    cur_ship  = (cur_id != '0);
    cur_water = on_board(cur_cx, cur_cy) && (cur_id == '0);
    hit_n     = acc_hit | cur_ship;
    near_n    = acc_near | (cur_water & nbr);
    max_n     = (cur_id > acc_max) ? cur_id : acc_max;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      score_q          <= 1'b0;
      xq               <= '0;
      yq               <= '0;
      bigq             <= 1'b0;
      row_i            <= 2'd0;
      col_i            <= 2'd0;
      shot             <= '0;
      acc_hit          <= 1'b0;
      acc_near         <= 1'b0;
      acc_max          <= '0;
      for (int i = 0; i < NUM_SHIPS; i++) ship_cnt[i] <= 4'd0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.hit          <= 1'b0;
      bus.near_miss    <= 1'b0;
      bus.miss         <= 1'b0;
      bus.biggest_ship <= '0;
      bus.sunk         <= '0;
      bus.hit_count    <= '0;
      bus.big_left     <= 2'(BIG_BOMBS);
      bus.wrong        <= 1'b0;
      bus.game_over    <= 1'b0;
    end else begin
      score_q       <= bus.score;
      bus.busy      <= (state_n == SCAN) || (state_n == REPORT);
      bus.done      <= (state_n == REPORT);
      bus.game_over <= (state_n == OVER);

      if (start) begin
        xq       <= CW'(bus.x);
        yq       <= CW'(bus.y);
        bigq     <= bus.big;
        row_i    <= 2'd0;
        col_i    <= 2'd0;
        acc_hit  <= 1'b0;
        acc_near <= 1'b0;
        acc_max  <= '0;
        if (legal && bus.big) bus.big_left <= bus.big_left - 2'd1;
        if (!legal) begin
          bus.wrong        <= 1'b1;
          bus.hit          <= 1'b0;
          bus.near_miss    <= 1'b0;
          bus.miss         <= 1'b0;
          bus.biggest_ship <= '0;
        end
      end

      if (state == SCAN) begin
        acc_hit  <= hit_n;
        acc_near <= near_n;
        acc_max  <= max_n;
        if (col_i == 2'd2) begin
          col_i <= 2'd0;
          row_i <= row_i + 2'd1;
        end else begin
          col_i <= col_i + 2'd1;
        end
        // Only the first hit on a ship cell counts toward damage.
        if (cur_ship && !shot[cur_lin]) begin
          shot[cur_lin] <= 1'b1;
          if (bus.hit_count != '1) bus.hit_count <= bus.hit_count + HIT_W'(1);
          if (cur_id <= ID_W'(NUM_SHIPS)) begin
            ship_cnt[sid] <= ship_cnt[sid] + 4'd1;
            if ((ship_cnt[sid] + 4'd1) == cur_len) bus.sunk[sid] <= 1'b1;
          end
        end
        if (cur_water) shot[cur_lin] <= 1'b1;
        if (last_cell) begin
          bus.wrong        <= 1'b0;
          bus.hit          <= hit_n;
          bus.miss         <= !hit_n;
          bus.near_miss    <= !hit_n && near_n;
          bus.biggest_ship <= (max_n == '0) ? '0 : (NUM_SHIPS'(1) << (max_n - ID_W'(1)));
        end
      end
    end
  end

endmodule
